// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch unit with a 2-entry output buffer.
//
// Issues one word-aligned read at a time to instruction memory, queues the
// returned words with their addresses, and hands them to the decoder through
// a valid/ready interface. A redirect restarts the fetch stream: queued words
// are flushed and a response still in flight is dropped.
//
// Optional feature (macro IFETCH_HALT_EN): fetching ECALL/EBREAK stops the
// fetch stream. The word itself is delivered, and `halted` then latches high
// until reset. With the macro undefined there is no HALT state and `halted`
// is tied low.
//
// Ports
//   clk            in   1   clock, all state on rising edge
//   rst            in   1   synchronous active-high reset
//   imem_req       out  1   instruction memory read request
//   imem_addr      out  32  word-aligned fetch address
//   imem_ack       in   1   imem_rdata valid, completes the request
//   imem_rdata     in   32  fetched instruction word
//   redirect_valid in   1   restart the fetch stream
//   redirect_pc    in   32  restart address (bits [1:0] forced to 0)
//   out_valid      out  1   out_ir/out_pc valid toward the decoder
//   out_ready      in   1   decoder accepts (transfer = valid & ready)
//   out_ir         out  32  instruction at buffer head
//   out_pc         out  32  address of out_ir
//   halted         out  1   fetch permanently stopped
// ---------------------------------------------------------------------------
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [31:0] out_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
`ifdef IFETCH_HALT_EN
    ,
    HALT  = 2'd3
`endif
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [1:0]  r_count;
  logic [31:0] r_ir0, r_pc0;   // head entry
  logic [31:0] r_ir1, r_pc1;   // second entry
  logic        r_halted;

  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_inc;
  logic        w_xfer;
  logic        w_redirect;
  logic        w_push;
  logic        w_halt_word;

  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_pc_inc      = r_pc + 32'd4;   // wraps 0xFFFF_FFFC -> 0
  assign w_xfer        = out_valid & out_ready;

`ifdef IFETCH_HALT_EN
  assign w_halt_word = (imem_rdata == 32'h0000_0073) || (imem_rdata == 32'h0010_0073);
  // Once halted, redirects no longer have any effect.
  assign w_redirect  = redirect_valid && !((r_state == HALT) && r_halted);
  assign halted      = r_halted;
`else
  assign w_halt_word = 1'b0;
  assign w_redirect  = redirect_valid;
  assign halted      = 1'b0;
`endif

  // A response is kept only when it completes a live request and no redirect
  // arrives in the same cycle.
  assign w_push = (r_state == REQ) && imem_ack && !redirect_valid;

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign out_valid = (r_count != 2'd0);
  assign out_ir    = r_ir0;
  assign out_pc    = r_pc0;

  // -------------------------------------------------------------------------
  // Fetch control FSM
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= {RESET_PC[31:2], 2'b00};
      r_imem_req  <= 1'b0;
      r_imem_addr <= {RESET_PC[31:2], 2'b00};
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end else if (r_count < 2'd2) begin
            r_state     <= REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
          end
        end

        REQ: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (imem_ack) begin
              r_state    <= IDLE;
              r_imem_req <= 1'b0;
            end else begin
              // Request stays on the bus; its response will be dropped.
              r_state <= DRAIN;
            end
          end else if (imem_ack) begin
            r_pc       <= w_pc_inc;
            r_imem_req <= 1'b0;
`ifdef IFETCH_HALT_EN
            r_state    <= w_halt_word ? HALT : IDLE;
`else
            r_state    <= IDLE;
`endif
          end
        end

        DRAIN: begin
          if (redirect_valid) r_pc <= w_redirect_pc;
          if (imem_ack) begin
            r_state    <= IDLE;
            r_imem_req <= 1'b0;
          end
        end

`ifdef IFETCH_HALT_EN
        HALT: begin
          if (w_redirect) begin
            r_pc    <= w_redirect_pc;
            r_state <= IDLE;
          end else if (!r_halted && w_xfer && (r_count == 2'd1)) begin
            // Nothing is enqueued after the halt word, so it is the last
            // entry: it leaves when the buffer drains from one.
            r_halted <= 1'b1;
          end
        end
`endif

        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // 2-entry output buffer, head in entry 0
  // -------------------------------------------------------------------------
  // NOTE: the buffer storage is reset (not just the count) because the head
  // entry drives out_ir/out_pc directly and must read as zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_ir0   <= 32'd0;
      r_pc0   <= 32'd0;
      r_ir1   <= 32'd0;
      r_pc1   <= 32'd0;
    end else if (w_redirect) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_xfer})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_ir0 <= imem_rdata;
            r_pc0 <= r_pc;
          end else begin
            r_ir1 <= imem_rdata;
            r_pc1 <= r_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ir0   <= r_ir1;
          r_pc0   <= r_pc1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push: count unchanged, order preserved.
          if (r_count == 2'd1) begin
            r_ir0 <= imem_rdata;
            r_pc0 <= r_pc;
          end else begin
            r_ir0 <= r_ir1;
            r_pc0 <= r_pc1;
            r_ir1 <= imem_rdata;
            r_pc1 <= r_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-005 imem_addr  output  32  SHALL be the word-aligned fetch address.
REQ-006 imem_ack  input  1  SHALL mark imem_rdata valid, completing the outstanding request.
REQ-007 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-008 redirect_valid  input  1  SHALL request a fetch-stream restart (branch/jump).
REQ-009 redirect_pc  input  32  SHALL be the restart address; bits [1:0] ignored, forced 0.
REQ-010 out_valid  output  1  SHALL mark out_ir/out_pc valid toward the decoder.
REQ-011 out_ready  input  1  SHALL mark decoder acceptance; transfer = out_valid & out_ready.
REQ-012 out_ir  output  32  SHALL be the instruction at buffer head (decoder ir input).
REQ-013 out_pc  output  32  SHALL be the address of out_ir.
REQ-014 halted  output  1  SHALL indicate fetch permanently stopped (see Configuration).

Function
REQ-015 States SHALL be IDLE, REQ, DRAIN, HALT; at most one memory request outstanding.
REQ-016 IDLE -> REQ when buffer count < 2 and no redirect; imem_req=1, imem_addr=pc.
REQ-017 In REQ and DRAIN, imem_req and imem_addr SHALL hold stable until the imem_ack cycle.
REQ-018 REQ with imem_ack, no redirect: enqueue {imem_rdata, pc}; pc <= pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0); -> IDLE.
REQ-019 Output buffer SHALL be a 2-entry FIFO; out_valid = (count != 0); out_ir/out_pc from head, registered.
REQ-020 Latency: imem_ack in cycle N with empty buffer SHALL give out_valid=1 with that word in cycle N+1.
REQ-021 Enqueue and transfer in the same cycle SHALL leave count unchanged and preserve order.
REQ-022 Count SHALL never exceed 2; no request issued while count == 2.
REQ-023 Redirect in IDLE, or in REQ coincident with imem_ack: flush buffer, discard response, pc <= redirect_pc, -> IDLE.
REQ-024 Redirect in REQ without imem_ack: flush buffer, pc <= redirect_pc, -> DRAIN; response on ack SHALL be discarded, then -> IDLE.
REQ-025 Redirect in DRAIN SHALL update pc to the newest redirect_pc and stay in DRAIN.
REQ-026 Redirect SHALL take priority over a coincident transfer; buffer empties regardless of out_ready.
REQ-027 out_valid SHALL be 0 in the cycle after any redirect.

Reset
REQ-028 rst=1 SHALL set state=IDLE, pc=RESET_PC, count=0, out_valid=0, imem_req=0, halted=0, out_ir=0, out_pc=0.
REQ-029 imem_req SHALL first assert in the cycle after rst deasserts.
REQ-030 rst during REQ/DRAIN SHALL abandon the request; an imem_ack during or after reset with no re-issued request SHALL be ignored.

Configuration
REQ-031 Macro IFETCH_HALT_EN defined: a word equal to 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK) SHALL be enqueued normally, then state -> HALT, no further requests.
REQ-032 With IFETCH_HALT_EN: halted SHALL assert the cycle after that word transfers out and stay 1 until rst.
REQ-033 With IFETCH_HALT_EN: redirect in HALT before halted=1 SHALL flush and resume (REQ-023); after halted=1 redirect SHALL be ignored.
REQ-034 Without IFETCH_HALT_EN: no HALT state; ECALL/EBREAK fetched as ordinary words; halted tied 0.

Verification
REQ-035 Reset, RESET_PC=0x100, 1-cycle ack, out_ready=1 -> addrs 0x100,0x104,0x108; out_pc matches; out_ir = rdata each in order.
REQ-036 out_ready=0 for 10 cycles -> count stops at 2, imem_req low; release -> 0x100,0x104 out in order, fetch resumes at 0x108.
REQ-037 Redirect to 0x203 while request pending (ack 3 cycles later) -> DRAIN, stale word dropped, next imem_addr=0x200, out_valid=0 until 0x200 word.
REQ-038 Redirect coincident with imem_ack and with transfer -> both words discarded, next fetch at redirect_pc.
REQ-039 pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
REQ-040 IFETCH_HALT_EN, word 0x00000073 at 0x10 -> no request after 0x10; halted=1 cycle after its transfer; later redirect ignored; rst clears halted.
